detection_frame_sequencer: RTL and testbench

- Parametrised successor to the fixed 5-scale / 800x600 face-detection top-level control.
- Gates camera pixels into NUM_CH scale channels and keeps the original-frame (x, y) coordinate.
- Waits until every channel requests the next pixel, then drains that cycle's candidate hits as one result word per hit.
- Result words are serialised over a valid/ready interface tagged with scale index, so they can be written to a result FIFO.

---
 rtl/detection_frame_sequencer_pkg.sv | 39 +++
 rtl/detection_frame_sequencer_coord.sv | 49 ++++
 rtl/detection_frame_sequencer.sv | 158 +++++++++++++++
 tb/tb_detection_frame_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/detection_frame_sequencer_pkg.sv
// Shared constants, result-word layout helpers and FSM state type for the
// detection frame sequencer and its scale channels.
package detection_pkg;

    // Default frame geometry and datapath widths
    localparam int unsigned FRAME_WIDTH_DEF     = 800;
    localparam int unsigned FRAME_HEIGHT_DEF    = 600;
    localparam int unsigned NUM_CH_DEF          = 5;
    localparam int unsigned PIXEL_WIDTH_DEF     = 16;
    localparam int unsigned COORD_WIDTH_DEF     = 12;
    localparam int unsigned FRAME_CNT_WIDTH_DEF = 8;

    // Channel index width; a single channel still gets a one-bit field
    function automatic int unsigned ch_idx_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Result word layout is {ch_idx, y, x}, x in the low bits
    function automatic int unsigned res_x_lsb(input int unsigned coord_width);
        return 0;
    endfunction

    function automatic int unsigned res_y_lsb(input int unsigned coord_width);
        return coord_width;
    endfunction

    function automatic int unsigned res_ch_lsb(input int unsigned coord_width);
        return 2 * coord_width;
    endfunction

    // Sequencer control states
    typedef enum logic [1:0] {
        WAIT_CH = 2'd0,
        REPORT  = 2'd1,
        ACCEPT  = 2'd2,
        SETTLE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/detection_frame_sequencer_coord.sv
// Raster x/y position counter with end-of-frame pulse and wrapping frame count.
module frame_coord_counter
    import detection_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH     = FRAME_WIDTH_DEF,
    parameter int unsigned FRAME_HEIGHT    = FRAME_HEIGHT_DEF,
    parameter int unsigned COORD_WIDTH     = COORD_WIDTH_DEF,
    parameter int unsigned FRAME_CNT_WIDTH = FRAME_CNT_WIDTH_DEF
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       advance,
    output logic [COORD_WIDTH-1:0]     x,
    output logic [COORD_WIDTH-1:0]     y,
    output logic                       frame_end,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(FRAME_HEIGHT - 1);

    // Step the raster position once per accepted pixel; pulse on the last pixel of a frame
    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            frame_end   <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_end <= 1'b0;
            if (advance) begin
                if (x == X_LAST) begin
                    x <= '0;
                    if (y == Y_LAST) begin
                        y           <= '0;
                        frame_end   <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                    end else begin
                        y <= y + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/detection_frame_sequencer.sv
// Top-level control: gates camera pixels to the scale channels, waits for all
// channels to ask for more, and drains their hits as {ch_idx, y, x} words.
module detection_frame_sequencer
    import detection_pkg::*;
#(
    parameter  int unsigned FRAME_WIDTH     = FRAME_WIDTH_DEF,
    parameter  int unsigned FRAME_HEIGHT    = FRAME_HEIGHT_DEF,
    parameter  int unsigned NUM_CH          = NUM_CH_DEF,
    parameter  int unsigned PIXEL_WIDTH     = PIXEL_WIDTH_DEF,
    parameter  int unsigned COORD_WIDTH     = COORD_WIDTH_DEF,
    parameter  int unsigned FRAME_CNT_WIDTH = FRAME_CNT_WIDTH_DEF,
    localparam int unsigned CH_IDX_WIDTH    = ch_idx_width(NUM_CH)
)
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 pixel_valid,
    input  logic [PIXEL_WIDTH-1:0]               pixel,
    output logic                                 o_pixel_ready,
    output logic                                 o_ch_pixel_valid,
    output logic [PIXEL_WIDTH-1:0]               o_ch_pixel,
    output logic [COORD_WIDTH-1:0]               o_ch_x,
    output logic [COORD_WIDTH-1:0]               o_ch_y,
    input  logic [NUM_CH-1:0]                    ch_pixel_request,
    input  logic [NUM_CH-1:0]                    ch_candidate,
    output logic                                 o_result_valid,
    output logic [CH_IDX_WIDTH+2*COORD_WIDTH-1:0] o_result_data,
    input  logic                                 result_ready,
    output logic                                 o_frame_end,
    output logic [FRAME_CNT_WIDTH-1:0]           o_frame_count
);

    localparam int unsigned RES_WIDTH = CH_IDX_WIDTH + 2 * COORD_WIDTH;

    seq_state_t              state;
    seq_state_t              state_next;
    logic                    first;
    logic [NUM_CH-1:0]       pend_mask;
    logic [NUM_CH-1:0]       pend_rest;
    logic                    latch_pend;
    logic                    accept_fire;
    logic                    report_fire;
    logic [CH_IDX_WIDTH-1:0] hit_idx;
    logic [COORD_WIDTH-1:0]  cnt_x;
    logic [COORD_WIDTH-1:0]  cnt_y;

    // Index of the lowest set bit; zero for an empty mask
    function automatic logic [CH_IDX_WIDTH-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
        logic [CH_IDX_WIDTH-1:0] idx;
        idx = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (mask[i-1]) begin
                idx = CH_IDX_WIDTH'(i - 1);
            end
        end
        return idx;
    endfunction

    // Clearing the lowest set bit is the same as dropping the word being reported
    assign hit_idx   = lowest_set(pend_mask);
    assign pend_rest = pend_mask & (pend_mask - 1'b1);

    frame_coord_counter #(
        .FRAME_WIDTH    (FRAME_WIDTH),
        .FRAME_HEIGHT   (FRAME_HEIGHT),
        .COORD_WIDTH    (COORD_WIDTH),
        .FRAME_CNT_WIDTH(FRAME_CNT_WIDTH)
    ) u_coord (
        .clk        (clk),
        .reset      (reset),
        .advance    (accept_fire),
        .x          (cnt_x),
        .y          (cnt_y),
        .frame_end  (o_frame_end),
        .frame_count(o_frame_count)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_CH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_next     = state;
        o_pixel_ready  = 1'b0;
        o_result_valid = 1'b0;
        o_result_data  = '0;
        latch_pend     = 1'b0;
        accept_fire    = 1'b0;
        report_fire    = 1'b0;
        case (state)
            WAIT_CH: begin
                if (&ch_pixel_request) begin
                    if (first || (ch_candidate == '0)) begin
                        state_next = ACCEPT;
                    end else begin
                        state_next = REPORT;
                        latch_pend = 1'b1;
                    end
                end
            end
            REPORT: begin
                o_result_valid = 1'b1;
                o_result_data  = RES_WIDTH'({hit_idx, o_ch_y, o_ch_x});
                if (result_ready) begin
                    report_fire = 1'b1;
                    if (pend_rest == '0) begin
                        state_next = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                o_pixel_ready = 1'b1;
                if (pixel_valid) begin
                    accept_fire = 1'b1;
                    state_next  = SETTLE;
                end
            end
            SETTLE: begin
                state_next = WAIT_CH;
            end
            default: begin
                state_next = WAIT_CH;
            end
        endcase
    end

    // Pending-hit mask, first-pixel flag and the registered channel broadcast
    always_ff @(posedge clk) begin
        if (reset) begin
            first            <= 1'b1;
            pend_mask        <= '0;
            o_ch_pixel_valid <= 1'b0;
            o_ch_pixel       <= '0;
            o_ch_x           <= '0;
            o_ch_y           <= '0;
        end else begin
            o_ch_pixel_valid <= accept_fire;
            if (latch_pend) begin
                pend_mask <= ch_candidate;
            end else if (report_fire) begin
                pend_mask <= pend_rest;
            end
            if (accept_fire) begin
                first      <= 1'b0;
                o_ch_pixel <= pixel;
                o_ch_x     <= cnt_x;
                o_ch_y     <= cnt_y;
            end
        end
    end

endmodule

// File: tb/tb_detection_frame_sequencer.sv
// Scoreboard bench for detection_frame_sequencer with a 4x2 frame and 3 channels.
module tb_detection_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixel_valid;
    logic [15:0] pixel;
    logic        o_pixel_ready;
    logic        o_ch_pixel_valid;
    logic [15:0] o_ch_pixel;
    logic [11:0] o_ch_x;
    logic [11:0] o_ch_y;
    logic [2:0]  ch_pixel_request;
    logic [2:0]  ch_candidate;
    logic        o_result_valid;
    logic [25:0] o_result_data;
    logic        result_ready;
    logic        o_frame_end;
    logic [7:0]  o_frame_count;

    int total = 0;
    int bad   = 0;

    // Expected channel broadcasts {pixel, x, y, frame_end} and result words {ch, y, x}
    logic [40:0] pix_q[$];
    logic [25:0] res_q[$];

    // Bench-side raster model
    logic        m_first;
    logic [11:0] m_x, m_y, m_last_x, m_last_y;
    int          m_frames;

    detection_frame_sequencer #(
        .FRAME_WIDTH    (4),
        .FRAME_HEIGHT   (2),
        .NUM_CH         (3),
        .PIXEL_WIDTH    (16),
        .COORD_WIDTH    (12),
        .FRAME_CNT_WIDTH(8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pixel_valid     (pixel_valid),
        .pixel           (pixel),
        .o_pixel_ready   (o_pixel_ready),
        .o_ch_pixel_valid(o_ch_pixel_valid),
        .o_ch_pixel      (o_ch_pixel),
        .o_ch_x          (o_ch_x),
        .o_ch_y          (o_ch_y),
        .ch_pixel_request(ch_pixel_request),
        .ch_candidate    (ch_candidate),
        .o_result_valid  (o_result_valid),
        .o_result_data   (o_result_data),
        .result_ready    (result_ready),
        .o_frame_end     (o_frame_end),
        .o_frame_count   (o_frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every channel strobe and every result handshake against the queues
    always @(negedge clk) begin
        if (o_ch_pixel_valid) begin
            if (pix_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ch_pixel_extra got=%0h expected=none", o_ch_pixel);
            end else begin
                check("ch_pixel", {o_ch_pixel, o_ch_x, o_ch_y, o_frame_end}, pix_q.pop_front());
            end
        end else if (o_frame_end) begin
            total++;
            bad++;
            $display("FAIL frame_end_stray got=1 expected=0");
        end
        if (o_result_valid && result_ready) begin
            if (res_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL result_extra got=%0h expected=none", o_result_data);
            end else begin
                check("result_word", o_result_data, res_q.pop_front());
            end
        end
    end

    // Offer one pixel; cand is the hit mask for the previous pixel. exp_wait=0 skips the latency check.
    task automatic send_pixel(input logic [15:0] pix, input logic [2:0] cand, input int exp_wait);
        int  waits;
        logic fe;
        if (!m_first) begin
            for (int i = 0; i < 3; i++) begin
                if (cand[i]) res_q.push_back({2'(i), m_last_y, m_last_x});
            end
        end
        ch_pixel_request = 3'b111;
        ch_candidate     = cand;
        waits = 0;
        while (waits == 0 || (!o_pixel_ready && waits < 50)) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!o_pixel_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got=0 expected=1");
            return;
        end
        if (exp_wait != 0) check("ready_latency", 64'(waits), 64'(exp_wait));
        pixel_valid      = 1'b1;
        pixel            = pix;
        ch_pixel_request = 3'b000;
        ch_candidate     = 3'b111;
        fe = (m_x == 12'd3) && (m_y == 12'd1);
        pix_q.push_back({pix, m_x, m_y, fe});
        m_last_x = m_x;
        m_last_y = m_y;
        m_first  = 1'b0;
        if (m_x == 12'd3) begin
            m_x = 12'd0;
            if (m_y == 12'd1) begin
                m_y = 12'd0;
                m_frames++;
            end else begin
                m_y = m_y + 12'd1;
            end
        end else begin
            m_x = m_x + 12'd1;
        end
        @(posedge clk);
        #1;
        pixel_valid  = 1'b0;
        ch_candidate = 3'b000;
    endtask

    task automatic check_all_zero();
        check("rst_pixel_ready",  64'(o_pixel_ready),    64'd0);
        check("rst_ch_valid",     64'(o_ch_pixel_valid), 64'd0);
        check("rst_ch_pixel",     64'(o_ch_pixel),       64'd0);
        check("rst_ch_x",         64'(o_ch_x),           64'd0);
        check("rst_ch_y",         64'(o_ch_y),           64'd0);
        check("rst_result_valid", 64'(o_result_valid),   64'd0);
        check("rst_result_data",  64'(o_result_data),    64'd0);
        check("rst_frame_end",    64'(o_frame_end),      64'd0);
        check("rst_frame_count",  64'(o_frame_count),    64'd0);
    endtask

    initial begin
        reset            = 1'b1;
        pixel_valid      = 1'b0;
        pixel            = '0;
        ch_pixel_request = '0;
        ch_candidate     = '0;
        result_ready     = 1'b1;
        m_first = 1'b1; m_x = '0; m_y = '0; m_last_x = '0; m_last_y = '0; m_frames = 0;

        @(posedge clk); #1;
        check_all_zero();
        @(posedge clk); #1;
        reset = 1'b0;

        // Frame 1: no hits; first pixel ignores candidates and is accepted one cycle after all-request
        send_pixel(16'h0001, 3'b111, 1);
        for (int p = 2; p <= 8; p++) send_pixel(16'(p), 3'b000, 2);
        check("frame_count_1", 64'(o_frame_count), 64'd1);

        // Frame 2: a single hit on (2,0), then a two-word drain for (2,1)
        send_pixel(16'h0009, 3'b000, 2);
        send_pixel(16'h000a, 3'b000, 2);
        send_pixel(16'h000b, 3'b000, 2);
        send_pixel(16'h000c, 3'b010, 3);
        send_pixel(16'h000d, 3'b000, 2);
        send_pixel(16'h000e, 3'b000, 2);
        send_pixel(16'h000f, 3'b000, 2);
        send_pixel(16'h0010, 3'b101, 4);
        check("frame_count_2", 64'(o_frame_count), 64'd2);

        // Partial request never advances
        ch_pixel_request = 3'b011;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("partial_req_ready", 64'(o_pixel_ready), 64'd0);
        end
        send_pixel(16'h0011, 3'b000, 1);
        for (int p = 18; p <= 23; p++) send_pixel(16'(p), 3'b000, 2);

        // Backpressure on the (2,1) drain; late candidate changes must be ignored
        result_ready = 1'b0;
        res_q.push_back({2'd0, 12'd1, 12'd2});
        res_q.push_back({2'd2, 12'd1, 12'd2});
        ch_pixel_request = 3'b111;
        ch_candidate     = 3'b101;
        for (int c = 0; c < 20 && !o_result_valid; c++) begin
            @(posedge clk); #1;
        end
        ch_candidate = 3'b010;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 64'(o_result_valid), 64'd1);
            check("bp_data",  64'(o_result_data),  {38'd0, 2'd0, 12'd1, 12'd2});
            check("bp_ready", 64'(o_pixel_ready),  64'd0);
            @(posedge clk); #1;
        end
        result_ready = 1'b1;
        send_pixel(16'h0018, 3'b000, 0);
        check("frame_count_3", 64'(o_frame_count), 64'd3);

        // Reset while the second of three words is pending
        send_pixel(16'h0019, 3'b000, 2);
        res_q.push_back({2'd0, 12'd0, 12'd0});
        ch_pixel_request = 3'b111;
        ch_candidate     = 3'b111;
        for (int c = 0; c < 20 && !o_result_valid; c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("second_word", 64'(o_result_data), {38'd0, 2'd1, 12'd0, 12'd0});
        result_ready     = 1'b0;
        reset            = 1'b1;
        ch_pixel_request = 3'b000;
        ch_candidate     = 3'b000;
        @(posedge clk); #1;
        check_all_zero();
        reset        = 1'b0;
        result_ready = 1'b1;
        m_first = 1'b1; m_x = '0; m_y = '0; m_frames = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("post_rst_no_word", 64'(o_result_valid), 64'd0);
        end
        send_pixel(16'h001a, 3'b111, 1);
        send_pixel(16'h001b, 3'b001, 3);
        check("frame_count_rst", 64'(o_frame_count), 64'd0);

        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pix_q_drained", 64'(pix_q.size()), 64'd0);
        check("res_q_drained", 64'(res_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
